// File: rtl/edge_event_pkg.sv
// Shared types and helpers for the multi-channel edge event capture unit.
//   edge_mode_t   : per-channel edge selection encoding
//   cnt_sat_value : all-ones saturation value for an event counter of width w
package edge_event_pkg;

    localparam int unsigned MAX_CNT_W = 64;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    // All-ones value of a w-bit counter, returned at full 64-bit width.
    function automatic logic [MAX_CNT_W-1:0] cnt_sat_value(input int unsigned w);
        if (w >= MAX_CNT_W) begin
            return '1;
        end
        return (MAX_CNT_W'(1) << w) - MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/edge_event_ch.sv
// One edge event channel: optional 2-flop synchroniser, glitch filter,
// one-cycle delay, edge qualification by mode, sticky flag and saturating
// event counter.
// Optional build macro: EDGE_EVENT_CAPTURE_SYNC_EN adds a 2-flop synchroniser
// in front of the filter (all latencies +2 cycles).
// Ports:
//   clk, anrst   : clock, asynchronous active-low reset
//   in           : raw input level
//   mode         : edge_mode_t encoding (off / rise / fall / both)
//   clr          : synchronous clear of sticky flag and counter
//   filt         : filtered level
//   edge_pulse   : one-cycle pulse per qualified edge
//   sticky       : event-seen flag
//   sticky_nxt_c : next value of sticky (feeds the top-level irq register)
//   cnt          : saturating event counter
module edge_event_ch
    import edge_event_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES    = 2,
    parameter int unsigned CNT_W            = 8,
    parameter bit          REGISTER_OUTPUTS = 1'b0
) (
    input  logic             clk,
    input  logic             anrst,
    input  logic             in,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             filt,
    output logic             edge_pulse,
    output logic             sticky,
    output logic             sticky_nxt_c,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_value(CNT_W));

    logic             in_s;
    logic             filt_q;
    logic             filt_d_q;
    logic             ev_c;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt_c;

`ifdef EDGE_EVENT_CAPTURE_SYNC_EN
    // Two-flop synchroniser for asynchronous source lines.
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], in};
        end
    end

    assign in_s = sync_q[1];
`else
    assign in_s = in;
`endif

    // Glitch filter: a new level must be seen on FILTER_CYCLES consecutive edges.
    if (FILTER_CYCLES == 0) begin : g_nofilt
        always_ff @(posedge clk or negedge anrst) begin
            if (!anrst) begin
                filt_q <= 1'b0;
            end else begin
                filt_q <= in_s;
            end
        end
    end else begin : g_filt
        localparam int unsigned     FC_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
        localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);

        logic [FC_W-1:0] fc_q;

        always_ff @(posedge clk or negedge anrst) begin
            if (!anrst) begin
                filt_q <= 1'b0;
                fc_q   <= '0;
            end else if (in_s != filt_q) begin
                if (fc_q == FC_LAST) begin
                    filt_q <= in_s;
                    fc_q   <= '0;
                end else begin
                    fc_q <= fc_q + FC_W'(1);
                end
            end else begin
                // Any agreeing sample discards a partial run.
                fc_q <= '0;
            end
        end
    end

    // Previous filtered level for edge detection.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            filt_d_q <= 1'b0;
        end else begin
            filt_d_q <= filt_q;
        end
    end

    // Edge qualification; mode is used live, so it holds no state.
    always_comb begin
        ev_c = 1'b0;
        unique case (edge_mode_t'(mode))
            EDGE_RISE: ev_c = filt_q & ~filt_d_q;
            EDGE_FALL: ev_c = ~filt_q & filt_d_q;
            EDGE_BOTH: ev_c = filt_q ^ filt_d_q;
            default:   ev_c = 1'b0;
        endcase
    end

    // Clear takes effect first, so a coincident event still counts once.
    always_comb begin
        sticky_nxt_c = sticky_q;
        cnt_nxt_c    = cnt_q;
        if (ev_c) begin
            sticky_nxt_c = 1'b1;
            if (clr) begin
                cnt_nxt_c = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_nxt_c = cnt_q + CNT_W'(1);
            end
        end else if (clr) begin
            sticky_nxt_c = 1'b0;
            cnt_nxt_c    = '0;
        end
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_nxt_c;
            cnt_q    <= cnt_nxt_c;
        end
    end

    // Pulse output: straight from qualification or delayed by one register.
    if (REGISTER_OUTPUTS) begin : g_pulse_reg
        logic pulse_q;

        always_ff @(posedge clk or negedge anrst) begin
            if (!anrst) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= ev_c;
            end
        end

        assign edge_pulse = pulse_q;
    end else begin : g_pulse_comb
        assign edge_pulse = ev_c;
    end

    assign filt   = filt_q;
    assign sticky = sticky_q;
    assign cnt    = cnt_q;

endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel edge event capture: WIDTH independent edge_event_ch channels
// plus a registered interrupt that is the OR of all sticky flags.
// Optional build macro: EDGE_EVENT_CAPTURE_SYNC_EN (input synchronisers,
// handled inside each channel).
// Ports:
//   clk, anrst : clock, asynchronous active-low reset
//   in         : raw input levels, one per channel
//   mode       : per-channel mode at [2i+1:2i] (00 off, 01 rise, 10 fall, 11 both)
//   clr        : per-channel synchronous clear of sticky flag and counter
//   filt       : filtered levels
//   edge_pulse : one-cycle pulse per qualified edge
//   sticky     : per-channel event-seen flags
//   cnt        : per-channel saturating counters, channel i at [i*CNT_W +: CNT_W]
//   irq        : registered OR of all sticky flags
module edge_event_capture
    import edge_event_pkg::*;
#(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned FILTER_CYCLES    = 2,
    parameter int unsigned CNT_W            = 8,
    parameter bit          REGISTER_OUTPUTS = 1'b0
) (
    input  logic                   clk,
    input  logic                   anrst,
    input  logic [WIDTH-1:0]       in,
    input  logic [2*WIDTH-1:0]     mode,
    input  logic [WIDTH-1:0]       clr,
    output logic [WIDTH-1:0]       filt,
    output logic [WIDTH-1:0]       edge_pulse,
    output logic [WIDTH-1:0]       sticky,
    output logic [WIDTH*CNT_W-1:0] cnt,
    output logic                   irq
);

    logic [WIDTH-1:0] sticky_nxt;
    logic             irq_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        edge_event_ch #(
            .FILTER_CYCLES    (FILTER_CYCLES),
            .CNT_W            (CNT_W),
            .REGISTER_OUTPUTS (REGISTER_OUTPUTS)
        ) u_ch (
            .clk          (clk),
            .anrst        (anrst),
            .in           (in[i]),
            .mode         (mode[2*i +: 2]),
            .clr          (clr[i]),
            .filt         (filt[i]),
            .edge_pulse   (edge_pulse[i]),
            .sticky       (sticky[i]),
            .sticky_nxt_c (sticky_nxt[i]),
            .cnt          (cnt[i*CNT_W +: CNT_W])
        );
    end

    // irq built from next-state sticky so it lands on the same edge as sticky.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |sticky_nxt;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed bench for edge_event_capture: a filtered instance (N=2, CNT_W=3,
// combinational pulse) and an unfiltered instance (N=0, CNT_W=2, registered pulse).
module tb_edge_event_capture;

`ifdef EDGE_EVENT_CAPTURE_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic        clk;
    logic        anrst;
    logic [3:0]  in;
    logic [7:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  filt;
    logic [3:0]  edge_pulse;
    logic [3:0]  sticky;
    logic [11:0] cnt;
    logic        irq;

    logic [1:0]  f_in;
    logic [3:0]  f_mode;
    logic [1:0]  f_clr;
    logic [1:0]  f_filt;
    logic [1:0]  f_pulse;
    logic [1:0]  f_sticky;
    logic [3:0]  f_cnt;
    logic        f_irq;

    int n_cmp = 0;
    int n_err = 0;
    int pc[4];

    edge_event_capture #(
        .WIDTH(4), .FILTER_CYCLES(2), .CNT_W(3), .REGISTER_OUTPUTS(1'b0)
    ) u_dut (
        .clk(clk), .anrst(anrst), .in(in), .mode(mode), .clr(clr),
        .filt(filt), .edge_pulse(edge_pulse), .sticky(sticky), .cnt(cnt), .irq(irq)
    );

    edge_event_capture #(
        .WIDTH(2), .FILTER_CYCLES(0), .CNT_W(2), .REGISTER_OUTPUTS(1'b1)
    ) u_fast (
        .clk(clk), .anrst(anrst), .in(f_in), .mode(f_mode), .clr(f_clr),
        .filt(f_filt), .edge_pulse(f_pulse), .sticky(f_sticky), .cnt(f_cnt), .irq(f_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step n cycles, tallying pulses seen on the main instance.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            for (int c = 0; c < 4; c++) begin
                if (edge_pulse[c]) pc[c]++;
            end
        end
    endtask

    initial begin
        anrst  = 1'b0;
        in     = 4'h0;
        mode   = 8'b11_10_01_11;
        clr    = 4'h0;
        f_in   = 2'b00;
        f_mode = 4'b11_11;
        f_clr  = 2'b00;
        for (int c = 0; c < 4; c++) pc[c] = 0;

        step();
        step();
        chk("rst_filt",   64'(filt),   64'h0);
        chk("rst_cnt",    64'(cnt),    64'h0);
        chk("rst_irq",    64'(irq),    64'h0);
        chk("rst_fpulse", 64'(f_pulse), 64'h0);
        anrst = 1'b1;
        run(3);

        // ch1 single-sample glitch is filtered away
        in[1] = 1'b1;
        step();
        in[1] = 1'b0;
        run(4 + SL);
        chk("glitch_filt",  64'(filt[1]),   64'h0);
        chk("glitch_pulse", 64'(pc[1]),     64'h0);
        chk("glitch_cnt",   64'(cnt[5:3]),  64'h0);
        chk("glitch_irq",   64'(irq),       64'h0);

        // ch0 rising edge, exact latency
        in[0] = 1'b1;
        run(SL);
        step();
        chk("rise_filt_early", 64'(filt[0]),       64'h0);
        step();
        chk("rise_filt",       64'(filt[0]),       64'h1);
        chk("rise_pulse",      64'(edge_pulse[0]), 64'h1);
        chk("rise_sticky_pre", 64'(sticky[0]),     64'h0);
        step();
        chk("rise_pulse_end",  64'(edge_pulse[0]), 64'h0);
        chk("rise_sticky",     64'(sticky[0]),     64'h1);
        chk("rise_cnt",        64'(cnt[2:0]),      64'h1);
        chk("rise_irq",        64'(irq),           64'h1);

        // ch2 falling-only: rise ignored, fall counted once
        for (int c = 0; c < 4; c++) pc[c] = 0;
        in[2] = 1'b1;
        run(4);
        in[2] = 1'b0;
        run(4);
        run(4);
        chk("fall_pulses", 64'(pc[2]),    64'h1);
        chk("fall_cnt",    64'(cnt[8:6]), 64'h1);

        // ch3 both edges, 10 toggles saturate a 3-bit counter at 7
        for (int c = 0; c < 4; c++) pc[c] = 0;
        for (int t = 0; t < 10; t++) begin
            in[3] = ~in[3];
            run(3);
        end
        run(2 + SL);
        chk("sat_pulses", 64'(pc[3]),     64'd10);
        chk("sat_cnt",    64'(cnt[11:9]), 64'h7);

        // ch0 to count 5, then clear coincident with an event
        for (int t = 0; t < 4; t++) begin
            in[0] = ~in[0];
            run(3);
        end
        run(3);
        chk("pre_clr_cnt", 64'(cnt[2:0]), 64'h5);
        in[0] = ~in[0];
        repeat (2 + SL) step();
        chk("clr_ev_pulse", 64'(edge_pulse[0]), 64'h1);
        clr = 4'b0001;
        step();
        chk("clr_ev_cnt",    64'(cnt[2:0]),  64'h1);
        chk("clr_ev_sticky", 64'(sticky[0]), 64'h1);
        clr = 4'b1101;
        step();
        clr = 4'b0000;
        chk("clr_cnt",    64'(cnt[2:0]),  64'h0);
        chk("clr_sticky", 64'(sticky),    64'h0);
        chk("clr_irq",    64'(irq),       64'h0);

        // unfiltered instance: toggle every cycle, pulse stays high, count saturates
        for (int i = 0; i < 8; i++) begin
            f_in[0] = ~f_in[0];
            step();
            if (i >= 2 + SL) chk($sformatf("fast_pulse%0d", i), 64'(f_pulse[0]), 64'h1);
        end
        run(3 + SL);
        chk("fast_pulse_end", 64'(f_pulse[0]), 64'h0);
        chk("fast_cnt0",      64'(f_cnt[1:0]), 64'h3);
        chk("fast_cnt1",      64'(f_cnt[3:2]), 64'h0);
        chk("fast_irq",       64'(f_irq),      64'h1);

        // reset mid-operation with ch0 held high
        in[0] = 1'b1;
        step();
        anrst = 1'b0;
        step();
        chk("mid_rst_filt",   64'(filt),    64'h0);
        chk("mid_rst_sticky", 64'(sticky),  64'h0);
        chk("mid_rst_cnt",    64'(cnt),     64'h0);
        chk("mid_rst_fcnt",   64'(f_cnt),   64'h0);
        chk("mid_rst_firq",   64'(f_irq),   64'h0);
        anrst = 1'b1;
        repeat (1 + SL) step();
        chk("post_rst_early", 64'(edge_pulse[0]), 64'h0);
        step();
        chk("post_rst_pulse", 64'(edge_pulse[0]), 64'h1);
        chk("post_rst_filt",  64'(filt[0]),       64'h1);
        step();
        chk("post_rst_cnt",   64'(cnt[2:0]),      64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
